mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 16-bit MEMORY block between the instruction-fetch port (IF, read-only) and the data-memory port (DM, read/write) of the RISC core.
- Latches one request per access and drives MEMORY's address, data and write lines. Returns read data and a one-cycle acknowledge to the winning requester.
- DM has priority over IF. A streak counter prevents fetch starvation.
- Sits between the core's fetch/memory stages and the MEMORY instance.

Parameters:
- ADDR_WIDTH, 16, width of all address buses.
- DATA_WIDTH, 16, width of all data buses.
- FETCH_STARVE_LIMIT, 4, max consecutive DM grants while IF is waiting before IF is forced to win (range 1..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- IF_REQ  input  1  fetch request; held high until IF_ACK.
- IF_ADDR  input  ADDR_WIDTH  fetch address; stable while IF_REQ high.
- IF_ACK  output  1  one-cycle pulse: fetch complete.
- IF_RDATA  output  DATA_WIDTH  fetched word.
- DM_REQ  input  1  data request; held high until DM_ACK.
- DM_WE  input  1  1 = write, 0 = read; stable while DM_REQ high.
- DM_ADDR  input  ADDR_WIDTH  data address.
- DM_WDATA  input  DATA_WIDTH  write data.
- DM_ACK  output  1  one-cycle pulse: data access complete.
- DM_RDATA  output  DATA_WIDTH  read word.
- MEM_ADDR  output  ADDR_WIDTH  to MEMORY address.
- MEM_DATA  output  DATA_WIDTH  to MEMORY write data.
- MEM_WRITE  output  1  to MEMORY write enable.
- MEMOUT  input  DATA_WIDTH  from MEMORY read data.

Behaviour:

Reset values:
- State is IDLE.
- Streak counter, latched address/data/we, IF_RDATA and DM_RDATA are all 0.
- IF_ACK, DM_ACK and MEM_WRITE are 0.
- MEM_ADDR and MEM_DATA are 0.

MEMORY contract:
- Writes on the rising edge when MEM_WRITE = 1.
- MEMOUT reflects the address captured at the previous rising edge.

States:
- IDLE, GRANT_IF, GRANT_DM, RESP_IF, RESP_DM.

IDLE:
- Arbitration is evaluated at each rising edge.
- If only one REQ is high, that port wins.
- If both are high: DM wins unless streak >= FETCH_STARVE_LIMIT, in which case IF wins.
- If neither is high, the state stays IDLE.
- The winner's ADDR (and, for DM, WE and WDATA) is latched. The next state is GRANT_x.

GRANT_x:
- MEM_ADDR and MEM_DATA are driven from the latched registers.
- MEM_WRITE = latched WE for DM, and always 0 for IF.
- The next state is unconditionally RESP_x.

RESP_x:
- x_ACK = 1 for exactly this cycle.
- x_RDATA = MEMOUT combinationally.
- At the exiting edge, x_RDATA is registered and held until the next RESP_x.
- For DM writes, DM_RDATA content is don't-care but still updates.
- MEM_WRITE = 0. MEM_ADDR holds the latched address.
- The next state is unconditionally IDLE. REQ is not sampled at this edge.

Timing:
- Latency: request seen at edge k, then GRANT during cycle k..k+1, then ACK during cycle k+1..k+2.
- Throughput: one access per 3 cycles.
- A requester may keep REQ high after ACK to issue a new access with new inputs. It is arbitrated at the next IDLE edge.

Streak counter:
- Updated on entry to GRANT_DM: increment, saturating at 15, if IF_REQ = 1 at that edge; otherwise clear.
- Cleared on entry to GRANT_IF.

Invariants:
- MEM_WRITE is never 1 outside GRANT_DM.
- IF_ACK and DM_ACK are never high together.
- Outputs outside GRANT and RESP hold their last values except MEM_WRITE (0) and ACKs (0).

Reset mid-operation:
- Immediately returns to IDLE and forces MEM_WRITE = 0 and both ACKs = 0, without waiting for a clock edge.
- The pending access is dropped with no ACK. The requester must re-arbitrate after RST falls.

Test Plan:
1. RST = 1 for 2 cycles with DM_REQ = 1, DM_WE = 1 -> MEM_WRITE = 0, no ACKs, RDATA = 0 throughout reset.
2. DM write ADDR = 300, WDATA = 300 -> MEM_WRITE = 1 for exactly one cycle, DM_ACK one cycle later. Then a DM read of 300 -> DM_RDATA = 300 in the ACK cycle, held afterwards.
3. IF_REQ alone, IF_ADDR = 299 (preloaded 0x1234) -> IF_ACK two cycles after the request edge, IF_RDATA = 0x1234, MEM_WRITE stays 0.
4. IF_REQ and DM_REQ rise together (DM read 300) -> DM_ACK first, then IF_ACK three cycles later. The ACKs never overlap.
5. IF_REQ held high while DM issues 6 back-to-back reads -> exactly 4 DM grants, then an IF grant, then the remaining DM grants. The streak counter resets on the IF grant.
6. Assert RST during GRANT_DM of a write to 299 (DATA = 1) -> MEM_WRITE drops in the same cycle, no DM_ACK, and a read of 299 afterwards returns its prior value.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch port and
// the data-memory port; DM has priority, a grant streak counter protects fetch.
module mem_arbiter #(
    parameter int ADDR_WIDTH         = 16,
    parameter int DATA_WIDTH         = 16,
    parameter int FETCH_STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IF_REQ,
    input  logic [ADDR_WIDTH-1:0] IF_ADDR,
    output logic                  IF_ACK,
    output logic [DATA_WIDTH-1:0] IF_RDATA,
    input  logic                  DM_REQ,
    input  logic                  DM_WE,
    input  logic [ADDR_WIDTH-1:0] DM_ADDR,
    input  logic [DATA_WIDTH-1:0] DM_WDATA,
    output logic                  DM_ACK,
    output logic [DATA_WIDTH-1:0] DM_RDATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DATA,
    output logic                  MEM_WRITE,
    input  logic [DATA_WIDTH-1:0] MEMOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_IF,
        S_GRANT_DM,
        S_RESP_IF,
        S_RESP_DM
    } state_t;

    localparam logic [3:0] LP_LIMIT = 4'(FETCH_STARVE_LIMIT);

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_streak;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  w_pick_dm;
    logic                  w_pick_if;
    logic                  w_starved;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign w_starved = (r_streak >= LP_LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; a reset forces IDLE, which clears ACKs and MEM_WRITE at once.
    always_comb begin
        w_next    = r_state;
        w_pick_dm = 1'b0;
        w_pick_if = 1'b0;
        IF_ACK    = 1'b0;
        DM_ACK    = 1'b0;
        MEM_WRITE = 1'b0;
        IF_RDATA  = r_if_rdata;
        DM_RDATA  = r_dm_rdata;
        case (r_state)
            S_IDLE: begin
                if (DM_REQ && !(IF_REQ && w_starved)) begin
                    w_pick_dm = 1'b1;
                    w_next    = S_GRANT_DM;
                end else if (IF_REQ) begin
                    w_pick_if = 1'b1;
                    w_next    = S_GRANT_IF;
                end
            end
            S_GRANT_IF: begin
                w_next = S_RESP_IF;
            end
            S_GRANT_DM: begin
                MEM_WRITE = r_we;
                w_next    = S_RESP_DM;
            end
            S_RESP_IF: begin
                IF_ACK   = 1'b1;
                IF_RDATA = MEMOUT;
                w_next   = S_IDLE;
            end
            S_RESP_DM: begin
                DM_ACK   = 1'b1;
                DM_RDATA = MEMOUT;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch and streak counter, updated only on the winning IDLE edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_streak <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
        end else if (w_pick_dm) begin
            r_streak <= IF_REQ ? sat_inc(r_streak) : 4'd0;
            r_addr   <= DM_ADDR;
            r_wdata  <= DM_WDATA;
            r_we     <= DM_WE;
        end else if (w_pick_if) begin
            r_streak <= 4'd0;
            r_addr   <= IF_ADDR;
            r_we     <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_state == S_RESP_IF) begin
                r_if_rdata <= MEMOUT;
            end
            if (r_state == S_RESP_DM) begin
                r_dm_rdata <= MEMOUT;
            end
        end
    end

    assign MEM_ADDR = r_addr;
    assign MEM_DATA = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a timestamp-based transaction model.
module tb_mem_arbiter;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IF_REQ;
    logic [AW-1:0] IF_ADDR;
    logic          IF_ACK;
    logic [DW-1:0] IF_RDATA;
    logic          DM_REQ;
    logic          DM_WE;
    logic [AW-1:0] DM_ADDR;
    logic [DW-1:0] DM_WDATA;
    logic          DM_ACK;
    logic [DW-1:0] DM_RDATA;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          MEM_WRITE;
    logic [DW-1:0] MEMOUT;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FETCH_STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WRITE(MEM_WRITE), .MEMOUT(MEMOUT)
    );

    function automatic logic [15:0] init_val(input int a);
        if (a == 299) return 16'h1234;
        return 16'((a * 40503) ^ 16'h5A5A);
    endfunction

    // MEMORY block: synchronous write, read data follows the previously captured address.
    logic [15:0] env_mem [0:511];
    logic [8:0]  env_raddr;
    logic        preload;
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= init_val(i);
        end else if (MEM_WRITE) begin
            env_mem[MEM_ADDR[8:0]] <= MEM_DATA;
        end
        env_raddr <= MEM_ADDR[8:0];
    end
    assign MEMOUT = env_mem[env_raddr];

    // Reference model state.
    logic [15:0] ref_mem [0:511];
    int          cyc, g_cyc, free_at, streak;
    bit          m_dm, m_we;
    logic [15:0] m_addr, m_wdata, exp_if_rd, exp_dm_rd;
    int          n_vec, n_err, wr_cycles, both_acks;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Grant at edge g: write lands at edge g+1, ACK window follows g+1, next arbitration at g+3.
    task automatic model_step();
        cyc++;
        if (RST) begin
            g_cyc     = -100;
            free_at   = 0;
            streak    = 0;
            exp_if_rd = '0;
            exp_dm_rd = '0;
            return;
        end
        if (cyc == g_cyc + 1) begin
            if (m_dm && m_we) ref_mem[m_addr[8:0]] = m_wdata;
            if (m_dm) exp_dm_rd = ref_mem[m_addr[8:0]];
            else      exp_if_rd = ref_mem[m_addr[8:0]];
        end
        if (cyc >= free_at && (IF_REQ || DM_REQ)) begin
            m_dm = DM_REQ && !(IF_REQ && streak >= LIMIT);
            if (m_dm) begin
                m_we    = DM_WE;
                m_addr  = DM_ADDR;
                m_wdata = DM_WDATA;
                streak  = IF_REQ ? ((streak < 15) ? streak + 1 : 15) : 0;
            end else begin
                m_we   = 1'b0;
                m_addr = IF_ADDR;
                streak = 0;
            end
            g_cyc   = cyc;
            free_at = cyc + 3;
        end
    endtask

    task automatic tick();
        bit e_grant, e_resp;
        @(posedge CLK);
        #1;
        model_step();
        e_grant = (cyc == g_cyc);
        e_resp  = (cyc == g_cyc + 1);
        chk_val("mem_write", MEM_WRITE, e_grant && m_dm && m_we);
        chk_val("if_ack", IF_ACK, e_resp && !m_dm);
        chk_val("dm_ack", DM_ACK, e_resp && m_dm);
        chk_val("if_rdata", IF_RDATA, exp_if_rd);
        chk_val("dm_rdata", DM_RDATA, exp_dm_rd);
        if (RST) begin
            chk_val("mem_addr_rst", MEM_ADDR, 0);
            chk_val("mem_data_rst", MEM_DATA, 0);
        end else if (e_grant || e_resp) begin
            chk_val("mem_addr", MEM_ADDR, m_addr);
        end
        if (e_grant && m_dm) chk_val("mem_data", MEM_DATA, m_wdata);
        if (MEM_WRITE) wr_cycles++;
        if (IF_ACK && DM_ACK) both_acks++;
        @(negedge CLK);
    endtask

    task automatic wait_ack(input bit dm, input int budget, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            tick();
            n++;
            got = dm ? DM_ACK : IF_ACK;
        end
        if (!got) chk_val(dm ? "dm_ack_timeout" : "if_ack_timeout", 0, 1);
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'(288 + $urandom_range(0, 31));
    endfunction

    initial begin
        int n, wr0, dm_done, dm_before;
        bit if_seen;
        n_vec = 0; n_err = 0; wr_cycles = 0; both_acks = 0;
        cyc = 0; g_cyc = -100; free_at = 0; streak = 0;
        m_dm = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        exp_if_rd = '0; exp_dm_rd = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        RST = 1'b1; preload = 1'b1;
        IF_REQ = 1'b0; IF_ADDR = '0;
        DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 16'd300; DM_WDATA = 16'd300;

        // Reset held two cycles with a DM write pending.
        tick();
        preload = 1'b0;
        tick();
        chk_val("rst_no_write", wr_cycles, 0);
        RST = 1'b0;

        // DM write of 300, then read back.
        wr0 = wr_cycles;
        wait_ack(1'b1, 10, n);
        chk_val("t2_wr_latency", n, 2);
        chk_val("t2_wr_pulses", wr_cycles - wr0, 1);
        DM_WE = 1'b0;
        wait_ack(1'b1, 10, n);
        chk_val("t2_rd_data", DM_RDATA, 300);
        DM_REQ = 1'b0;
        tick();
        chk_val("t2_rd_hold", DM_RDATA, 300);

        // Lone fetch of preloaded word.
        wr0 = wr_cycles;
        IF_REQ = 1'b1; IF_ADDR = 16'd299;
        wait_ack(1'b0, 10, n);
        chk_val("t3_if_latency", n, 2);
        chk_val("t3_if_rdata", IF_RDATA, 16'h1234);
        chk_val("t3_no_write", wr_cycles - wr0, 0);
        IF_REQ = 1'b0;
        tick();

        // Simultaneous requests: DM first, IF three cycles later.
        IF_REQ = 1'b1; IF_ADDR = 16'd299;
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 16'd300;
        wait_ack(1'b1, 10, n);
        chk_val("t4_dm_first", n, 2);
        DM_REQ = 1'b0;
        wait_ack(1'b0, 10, n);
        chk_val("t4_if_gap", n, 3);
        chk_val("t4_if_rdata", IF_RDATA, 16'h1234);
        IF_REQ = 1'b0;
        tick();

        // Starvation guard: six back-to-back DM reads with IF waiting.
        IF_REQ = 1'b1; IF_ADDR = 16'd299;
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 16'd300;
        dm_done = 0; dm_before = 0; if_seen = 1'b0;
        for (int k = 0; k < 60 && !(dm_done == 6 && if_seen); k++) begin
            tick();
            if (DM_ACK) begin
                dm_done++;
                if (!if_seen) dm_before++;
                if (dm_done == 6) DM_REQ = 1'b0;
                else DM_ADDR = 16'(300 + dm_done);
            end
            if (IF_ACK) begin
                if_seen = 1'b1;
                IF_REQ  = 1'b0;
            end
        end
        chk_val("t5_dm_before_if", dm_before, LIMIT);
        chk_val("t5_dm_total", dm_done, 6);
        chk_val("t5_if_served", if_seen, 1);
        tick();

        // Reset during a DM write grant drops the write immediately.
        DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 16'd299; DM_WDATA = 16'd1;
        tick();
        chk_val("t6_write_active", MEM_WRITE, 1);
        RST = 1'b1;
        #1;
        chk_val("t6_write_dropped", MEM_WRITE, 0);
        chk_val("t6_no_ack", DM_ACK, 0);
        DM_REQ = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 16'd299;
        wait_ack(1'b1, 10, n);
        chk_val("t6_prior_value", DM_RDATA, 16'h1234);
        DM_REQ = 1'b0;
        tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (IF_REQ) begin
                if (IF_ACK) begin
                    if ($urandom_range(0, 1) == 1) IF_ADDR = rand_addr();
                    else IF_REQ = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                IF_REQ  = 1'b1;
                IF_ADDR = rand_addr();
            end
            if (DM_REQ) begin
                if (DM_ACK) begin
                    if ($urandom_range(0, 3) != 0) begin
                        DM_ADDR  = rand_addr();
                        DM_WE    = 1'($urandom_range(0, 1));
                        DM_WDATA = 16'($urandom);
                    end else begin
                        DM_REQ = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 1) == 0) begin
                DM_REQ   = 1'b1;
                DM_ADDR  = rand_addr();
                DM_WE    = 1'($urandom_range(0, 1));
                DM_WDATA = 16'($urandom);
            end
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 199) == 0) RST = 1'b1;
        end
        chk_val("acks_never_overlap", both_acks, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
